imm_ext_pipe: RTL
=================

IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 Parameter DATA_W, default 32: width of the extended immediate output.
REQ-002 Parameter IMM_W, default 16: width of the immediate field taken from instr[IMM_W-1:0].
REQ-003 Parameter CNT_W, default 16: width of the accepted-transaction counter.
REQ-004 Parameters SHALL satisfy DATA_W >= IMM_W+2; any other setting is unsupported and SHALL fail elaboration.
REQ-005 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-006 reset  input  1  synchronous reset, active-low.
REQ-007 in_valid  input  1  upstream holds a valid instr/ext_op.
REQ-008 in_ready  output  1  block can accept this cycle.
REQ-009 instr  input  32  instruction word.
REQ-010 ext_op  input  3  extension mode, see REQ-015.
REQ-011 flush  input  1  discard all buffered and incoming entries.
REQ-012 out_valid  output  1  imm/err are valid.
REQ-013 out_ready  input  1  downstream accepts this cycle.
REQ-014 imm  output  DATA_W  extended immediate; err  output  1  reserved-mode flag; acc_cnt  output  CNT_W  count of accepted inputs.

Function
REQ-015 ext_op decode: 0 zero-extend; 1 sign-extend from bit IMM_W-1; 2 upper-load, imm field placed at [DATA_W-1:DATA_W-IMM_W] with zeros below; 3 sign-extend then shift left 2; 4 zero-extend then shift left 2; 5 instr[10:6] zero-extended; 6-7 reserved: imm=0 and err=1.
REQ-016 Shift-left-2 modes SHALL fill the two LSBs with 0 and discard bits shifted out above DATA_W-1.
REQ-017 Extension SHALL be computed combinationally at input and stored already extended; imm/err SHALL be driven from registered state only.
REQ-018 A transfer in SHALL occur when in_valid && in_ready at a rising edge; a transfer out when out_valid && out_ready.
REQ-019 Storage SHALL be a 2-entry FIFO (head/tail registers, occupancy count 0..2) preserving input order.
REQ-020 in_ready SHALL equal (count != 2) and SHALL NOT depend combinationally on out_ready.
REQ-021 out_valid SHALL equal (count != 0); imm/err SHALL show the head entry.
REQ-022 Latency: an entry accepted into an empty FIFO SHALL appear on out_valid/imm the next cycle.
REQ-023 Simultaneous push and pop at count 1: count stays 1, new entry becomes head the next cycle.
REQ-024 Pop at count 2 with no push (in_ready=0): count becomes 1, second entry becomes head.
REQ-025 out_valid high with out_ready low SHALL hold imm/err stable until transfer.
REQ-026 flush=1 SHALL set count to 0 next cycle, dropping stored entries and any input presented that cycle; flush wins over push and pop.
REQ-027 acc_cnt SHALL increment by 1 per accepted input (including later-flushed ones), wrap from 2^CNT_W-1 to 0, and not be cleared by flush.

Reset
REQ-028 While reset=0 at a rising edge: count=0, out_valid=0, imm=0, err=0, acc_cnt=0; all FIFO data registers SHALL be cleared to 0.
REQ-029 in_ready SHALL be 0 while reset is low and 1 from the first cycle after reset deasserts.
REQ-030 Reset asserted mid-transfer SHALL discard all entries; no output transfer SHALL complete on that edge.

Verification
REQ-031 Modes: instr[15:0]=0x8004 with ext_op 0/1/2/3/4 -> imm 0x00008004 / 0xFFFF8004 / 0x80040000 / 0xFFFE0010 / 0x00020010; instr[10:6]=5'h1F with ext_op 5 -> 0x0000001F.
REQ-032 Reserved: ext_op 6 -> imm 0x00000000, err 1; next entry with ext_op 1 -> err 0.
REQ-033 Backpressure: out_ready=0, push three entries A,B,C -> A,B accepted, in_ready 0 after second, C held; release out_ready -> outputs A,B,C in order, one per cycle once streaming.
REQ-034 Streaming: in_valid and out_ready tied high for 10 cycles -> one output per cycle after 1-cycle latency, acc_cnt=10.
REQ-035 Flush with count=2 and in_valid=1 -> next cycle out_valid=0, count 0, acc_cnt unchanged since the flushed input was not accepted... it is accepted only if in_ready was 1 that cycle.
REQ-036 Wrap: CNT_W=4, accept 17 inputs -> acc_cnt=1; reset low mid-stream -> all outputs 0 next cycle, in_ready 1 one cycle after release.

Source files
------------

// File: rtl/imm_ext_pipe.sv
// Immediate extender feeding a 2-entry FIFO: the immediate is extended on the way in,
// then buffered with a valid/ready handshake on each side, and accepted inputs are counted.
module imm_ext_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [2:0]        ext_op,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] imm,
    output logic              err,
    output logic [CNT_W-1:0]  acc_cnt
);

    localparam int unsigned PadW = DATA_W - IMM_W;

    if (DATA_W < IMM_W + 2 || IMM_W < 1 || IMM_W > 32 || CNT_W < 1) begin : g_bad_params
        $error("imm_ext_pipe: unsupported DATA_W/IMM_W/CNT_W combination");
    end

    logic [IMM_W-1:0]  w_field;
    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_ext_imm;
    logic              w_ext_err;
    logic              w_push;
    logic              w_pop;
    logic              w_unused;

    logic [DATA_W-1:0] r_imm0;
    logic [DATA_W-1:0] r_imm1;
    logic              r_err0;
    logic              r_err1;
    logic [1:0]        r_count;
    logic [CNT_W-1:0]  r_acc;
    logic              r_live;

    // Only the immediate field and instr[10:6] are decoded; the rest is intentionally ignored.
    assign w_unused = ^instr;

    assign w_field = instr[IMM_W-1:0];
    assign w_zext  = {{PadW{1'b0}}, w_field};
    assign w_sext  = {{PadW{w_field[IMM_W-1]}}, w_field};

    always_comb begin
        w_ext_imm = '0;
        w_ext_err = 1'b0;
        case (ext_op)
            3'd0:    w_ext_imm = w_zext;
            3'd1:    w_ext_imm = w_sext;
            3'd2:    w_ext_imm = {w_field, {PadW{1'b0}}};
            3'd3:    w_ext_imm = {w_sext[DATA_W-3:0], 2'b00};
            3'd4:    w_ext_imm = {w_zext[DATA_W-3:0], 2'b00};
            3'd5:    w_ext_imm = DATA_W'(instr[10:6]);
            default: w_ext_err = 1'b1;
        endcase
    end

    // r_live keeps in_ready low through reset and releases it one cycle after deassertion.
    assign in_ready  = r_live && (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign imm       = r_imm0;
    assign err       = r_err0;
    assign acc_cnt   = r_acc;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_imm0  <= '0;
            r_imm1  <= '0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
            r_count <= 2'd0;
            r_acc   <= '0;
            r_live  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            // Counted even when a flush drops the entry in the same cycle.
            if (w_push) begin
                r_acc <= r_acc + CNT_W'(1);
            end
            if (flush) begin
                r_count <= 2'd0;
            end else begin
                case (r_count)
                    2'd0: begin
                        if (w_push) begin
                            r_imm0  <= w_ext_imm;
                            r_err0  <= w_ext_err;
                            r_count <= 2'd1;
                        end
                    end
                    2'd1: begin
                        if (w_push && w_pop) begin
                            r_imm0 <= w_ext_imm;
                            r_err0 <= w_ext_err;
                        end else if (w_push) begin
                            r_imm1  <= w_ext_imm;
                            r_err1  <= w_ext_err;
                            r_count <= 2'd2;
                        end else if (w_pop) begin
                            r_count <= 2'd0;
                        end
                    end
                    2'd2: begin
                        if (w_pop) begin
                            r_imm0  <= r_imm1;
                            r_err0  <= r_err1;
                            r_count <= 2'd1;
                        end
                    end
                    default: r_count <= 2'd0;
                endcase
            end
        end
    end

endmodule
